argmax_row_scheduler: RTL and testbench

Controller that sequences a row-wise argmax over a 2-D tensor held in a read-only buffer. It issues one buffer read per cycle, compares elements as they return, and emits one argmax index per row over a valid/ready output. It sits between the layer command interface (start/config) and the activation buffer read port, replacing per-element host sequencing of the argmax operator.

---
 rtl/argmax_row_scheduler.sv | 139 +++++++++++++
 tb/tb_argmax_row_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_row_scheduler.sv
// Row-wise argmax sequencer: streams one buffer read per cycle, tracks the
// running signed maximum of each row and hands out one column index per row
// over a valid/ready port.
module argmax_row_scheduler #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [IDX_W-1:0]  cfg_rows,
  input  logic [IDX_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W-1:0]  out_row,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FINISH} state_t;

  state_t              state;
  logic [IDX_W-1:0]    rows_r;
  logic [IDX_W-1:0]    len_r;
  logic [ADDR_W-1:0]   stride_r;
  logic [ADDR_W-1:0]   row_base;
  logic [IDX_W-1:0]    col;
  logic [IDX_W-1:0]    row;
  logic                pend;
  logic [IDX_W-1:0]    pend_col;
  logic [DATA_W-1:0]   cur_max;
  logic [IDX_W-1:0]    cur_idx;
  logic                take;
  logic [IDX_W-1:0]    nxt_idx;

  // Returning element wins if it opens the row or is strictly greater (ties keep lowest index)
  always_comb begin
    take    = pend && ((pend_col == '0) || ($signed(rd_data) > $signed(cur_max)));
    nxt_idx = take ? pend_col : cur_idx;
  end

  // Control FSM, read address generation, running max and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rows_r    <= '0;
      len_r     <= '0;
      stride_r  <= '0;
      row_base  <= '0;
      col       <= '0;
      row       <= '0;
      pend      <= 1'b0;
      pend_col  <= '0;
      cur_max   <= '0;
      cur_idx   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // rd_data arrives one cycle after rd_en, so remember which column is in flight
      pend     <= rd_en;
      pend_col <= col;
      done     <= 1'b0;
      if (take) begin
        cur_max <= rd_data;
        cur_idx <= pend_col;
      end
      case (state)
        IDLE: begin
          if (start) begin
            rows_r   <= cfg_rows;
            len_r    <= cfg_len;
            stride_r <= cfg_stride;
            row_base <= cfg_base;
            row      <= '0;
            col      <= '0;
            if ((cfg_rows == '0) || (cfg_len == '0)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= cfg_base;
              state   <= READ;
            end
          end
        end
        READ: begin
          if (col == len_r - IDX_W'(1)) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            col     <= col + IDX_W'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          out_valid <= 1'b1;
          out_idx   <= nxt_idx;
          out_row   <= row;
          state     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == rows_r - IDX_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              row      <= row + IDX_W'(1);
              row_base <= row_base + stride_r;
              rd_addr  <= row_base + stride_r;
              rd_en    <= 1'b1;
              col      <= '0;
              state    <= READ;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_row_scheduler.sv
// Bench for argmax_row_scheduler: directed commands against a buffer model,
// a per-cycle reference check of reads/results/busy/done, and literal pins.
module tb_argmax_row_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [15:0] cfg_rows = '0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_stride = '0;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_idx;
  logic [15:0] out_row;
  logic        busy;
  logic        done;

  argmax_row_scheduler #(.DATA_W(32), .IDX_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
    .cfg_len(cfg_len), .cfg_stride(cfg_stride), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_row(out_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // buffer: data valid the cycle after the read strobe
  logic [31:0] mem [0:65535];
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'hDEADBEEF;

  // reference state for the current command
  int m_base, m_rows, m_len, m_stride;
  bit m_active = 0, m_zero = 0;
  int col_cnt = 0, hs = 0, e0 = 0;
  int first_rd, last_rd, first_valid, done_cyc, done_cnt = 0;
  int rd_log[$];
  int res_idx[$];
  int res_row[$];
  bit prev_valid = 0, prev_ready = 0;
  logic [15:0] prev_idx, prev_row;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // argmax of row r from the buffer contents, first maximum wins
  function automatic int model_idx(input int r);
    logic [15:0] a;
    logic signed [31:0] best;
    logic signed [31:0] v;
    int bi = 0;
    best = 0;
    for (int c = 0; c < m_len; c++) begin
      a = 16'(m_base + m_stride * r + c);
      v = mem[a];
      if (c == 0 || v > best) begin
        best = v;
        bi = c;
      end
    end
    return bi;
  endfunction

  // per-cycle compare against the reference
  always @(negedge clk) begin
    int rel;
    logic [15:0] exp_addr;
    if (rst) begin
      m_active = 0; col_cnt = 0; hs = 0; prev_valid = 0; prev_ready = 0;
    end else begin
      rel = cyc - e0 + 1;
      chk("busy", {31'd0, busy}, {31'd0, m_active && !m_zero && (hs < m_rows)});
      if (rd_en) begin
        chk("rd_allowed", 32'(m_active && !m_zero && col_cnt < m_len), 32'd1);
        exp_addr = 16'(m_base + m_stride * hs + col_cnt);
        chk("rd_addr", {16'd0, rd_addr}, {16'd0, exp_addr});
        rd_log.push_back(int'(rd_addr));
        if (first_rd < 0) first_rd = rel;
        last_rd = rel;
        col_cnt++;
      end
      if (out_valid) begin
        chk("valid_allowed", 32'(m_active && !m_zero && col_cnt == m_len && hs < m_rows), 32'd1);
        chk("out_idx", {16'd0, out_idx}, 32'(model_idx(hs)));
        chk("out_row", {16'd0, out_row}, 32'(hs));
        if (prev_valid && !prev_ready) begin
          chk("hold_idx", {16'd0, out_idx}, {16'd0, prev_idx});
          chk("hold_row", {16'd0, out_row}, {16'd0, prev_row});
        end
        if (first_valid < 0) first_valid = rel;
        if (out_ready) begin
          res_idx.push_back(int'(out_idx));
          res_row.push_back(int'(out_row));
          hs++;
          col_cnt = 0;
        end
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_idx = out_idx; prev_row = out_row;
      if (done) begin
        done_cnt++;
        chk("done_allowed", 32'(m_active && (m_zero || hs == m_rows)), 32'd1);
        done_cyc = rel;
        m_active = 0;
      end
    end
  end

  task automatic start_cmd(input int base, input int rows, input int len, input int stride);
    @(posedge clk); #1;
    start = 1; cfg_base = 16'(base); cfg_rows = 16'(rows); cfg_len = 16'(len); cfg_stride = 16'(stride);
    @(posedge clk); #1;
    start = 0;
    cfg_base = 16'h5555; cfg_rows = 16'd7; cfg_len = 16'd9; cfg_stride = 16'd3;
    m_base = base; m_rows = rows; m_len = len; m_stride = stride;
    m_active = 1; m_zero = (rows == 0 || len == 0);
    col_cnt = 0; hs = 0; e0 = cyc;
    first_rd = -1; last_rd = -1; first_valid = -1; done_cyc = -1;
    rd_log.delete(); res_idx.delete(); res_row.delete();
  endtask

  task automatic wait_done(input int maxc);
    int seen = done_cnt;
    int n = 0;
    while (done_cnt == seen && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, {31'd0, rd_en}, 32'd0);
    chk({tag, "_rd_addr"}, {16'd0, rd_addr}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_idx"}, {16'd0, out_idx}, 32'd0);
    chk({tag, "_out_row"}, {16'd0, out_row}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dc;
    int n;
    // T1 data
    mem[16'h0040] = 3; mem[16'h0041] = 9; mem[16'h0042] = 2; mem[16'h0043] = 9;
    // T2 data
    mem[16'h0100] = -5; mem[16'h0101] = -2; mem[16'h0102] = -7;
    mem[16'h0200] = 32'h80000000;
    // T3 data
    mem[16'h0010] = 1; mem[16'h0011] = 5; mem[16'h0012] = 4;
    mem[16'h0018] = 7; mem[16'h0019] = 7; mem[16'h001A] = 8;
    // T4 data
    mem[16'hFFFE] = 10; mem[16'hFFFF] = -1; mem[16'h0000] = 20;
    // T6 data
    mem[16'h0300] = 4;  mem[16'h0301] = -3;   mem[16'h0302] = 12; mem[16'h0303] = 12;
    mem[16'h0304] = 0;  mem[16'h0305] = 11;   mem[16'h0306] = -100; mem[16'h0307] = 5;

    #3;
    check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // T1: timing and tie handling
    start_cmd(16'h0040, 1, 4, 4);
    wait_done(40);
    chk("t1_first_rd_cycle", 32'(first_rd), 32'd1);
    chk("t1_last_rd_cycle", 32'(last_rd), 32'd4);
    chk("t1_valid_cycle", 32'(first_valid), 32'd6);
    chk("t1_done_cycle", 32'(done_cyc), 32'd7);
    chk("t1_nres", 32'(res_idx.size()), 32'd1);
    if (res_idx.size() == 1) begin
      chk("t1_idx", 32'(res_idx[0]), 32'd1);
      chk("t1_row", 32'(res_row[0]), 32'd0);
    end
    chk("t1_addr_last", 32'(rd_log.size() == 4 ? rd_log[3] : -1), 32'h43);

    // T2: negative values, started the cycle after done
    start_cmd(16'h0100, 1, 3, 0);
    wait_done(40);
    chk("t2a_first_rd_cycle", 32'(first_rd), 32'd1);
    chk("t2a_idx", 32'(res_idx.size() == 1 ? res_idx[0] : -1), 32'd1);
    start_cmd(16'h0200, 1, 1, 0);
    wait_done(40);
    chk("t2b_idx", 32'(res_idx.size() == 1 ? res_idx[0] : -1), 32'd0);
    chk("t2b_valid_cycle", 32'(first_valid), 32'd3);

    // T3: two rows with a 3-cycle stall on row 0
    out_ready = 0;
    dc = done_cnt;
    start_cmd(16'h0010, 2, 3, 8);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (!out_valid) chk("t3_valid_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 out_ready = 1;
    wait_done(60);
    repeat (3) @(negedge clk);
    chk("t3_done_once", 32'(done_cnt - dc), 32'd1);
    chk("t3_nres", 32'(res_idx.size()), 32'd2);
    if (res_idx.size() == 2) begin
      chk("t3_idx0", 32'(res_idx[0]), 32'd1);
      chk("t3_row0", 32'(res_row[0]), 32'd0);
      chk("t3_idx1", 32'(res_idx[1]), 32'd2);
      chk("t3_row1", 32'(res_row[1]), 32'd1);
    end
    chk("t3_nreads", 32'(rd_log.size()), 32'd6);
    chk("t3_done_cycle", 32'(done_cyc), 32'd14);

    // T4: address wrap and a start pulse while busy
    dc = done_cnt;
    start_cmd(16'hFFFE, 1, 3, 0);
    start = 1; cfg_base = 16'h3000; cfg_rows = 16'd1; cfg_len = 16'd2;
    @(posedge clk); #1 start = 0;
    wait_done(40);
    chk("t4_nreads", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      chk("t4_addr0", 32'(rd_log[0]), 32'hFFFE);
      chk("t4_addr1", 32'(rd_log[1]), 32'hFFFF);
      chk("t4_addr2", 32'(rd_log[2]), 32'h0000);
    end
    chk("t4_idx", 32'(res_idx.size() == 1 ? res_idx[0] : -1), 32'd2);
    chk("t4_done_once", 32'(done_cnt - dc), 32'd1);

    // T5: zero-size commands
    start_cmd(16'h0040, 5, 0, 1);
    wait_done(10);
    chk("t5a_done_cycle", 32'(done_cyc), 32'd1);
    chk("t5a_no_reads", 32'(rd_log.size()), 32'd0);
    chk("t5a_no_valid", 32'(first_valid), 32'hFFFFFFFF);
    start_cmd(16'h0040, 0, 5, 1);
    wait_done(10);
    chk("t5b_done_cycle", 32'(done_cyc), 32'd1);
    chk("t5b_no_reads", 32'(rd_log.size()), 32'd0);
    chk("t5b_no_valid", 32'(first_valid), 32'hFFFFFFFF);

    // T6: reset in the middle of a row
    start_cmd(16'h0300, 1, 8, 0);
    @(posedge clk); #1 rst = 1;
    #1;
    check_idle_outputs("midrst");
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (12) @(negedge clk);
    chk("t6_no_done_after_abort", 32'(done_cnt), 32'(dc));
    start_cmd(16'h0300, 1, 8, 0);
    wait_done(40);
    chk("t6_idx", 32'(res_idx.size() == 1 ? res_idx[0] : -1), 32'd2);
    chk("t6_row", 32'(res_row.size() == 1 ? res_row[0] : -1), 32'd0);
    chk("t6_valid_cycle", 32'(first_valid), 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
